// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared definitions for the diff scoreboard:
//   state_e  - FSM state encoding (IDLE=0, WAIT=1, RUN=2, DONE=3)
//   SB_CNT_W - default width of the sample/error counters
//   sat_add  - saturating add helper, evaluated on 64-bit operands and
//              clamped to the all-ones value of a caller-supplied width
// -----------------------------------------------------------------------------
package sb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int SB_CNT_W = 32;

  // Adds a + b and clamps the result to (2**w)-1. Callers zero-extend their
  // operands to 64 bits; widths above 64 are not supported.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    sum   = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) begin
      return max_v;
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Registered accumulator that adds inc_val when inc_en is high and sticks at
// all-ones instead of wrapping.
// Ports:
//   clk     in   clock, posedge
//   reset   in   synchronous, active-low; clears q
//   clr     in   synchronous clear (takes priority over inc_en)
//   inc_en  in   accumulate inc_val this cycle
//   inc_val in   W-bit increment
//   q       out  W-bit count
// -----------------------------------------------------------------------------
module sat_counter
  import sb_pkg::*;
#(
  parameter int W = SB_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [W-1:0] inc_val,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [63:0]  sum_ext;

  always_comb begin
    sum_ext = sat_add(64'(q_q), 64'(inc_val), W);
    q_d     = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc_en) begin
      q_d = sum_ext[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/diff_scoreboard.sv
// -----------------------------------------------------------------------------
// diff_scoreboard
// Consumes the arithmetic monitor's ready flag and XOR diff word, and keeps
// run control, sample/error counts, first-failure capture, a sticky OR mask of
// failing bits and an optional automatic halt at an error threshold.
//
// Optional build macro: DIFF_SCOREBOARD_BITCNT_EN adds o_bit_err_cnt, a
// saturating accumulation of the popcount of every valid diff word.
//
// Ports:
//   clk           in   clock, posedge
//   reset         in   synchronous, active-low
//   i_start       in   pulse, arms a new run (IDLE/DONE -> WAIT, clears results)
//   i_stop        in   pulse, ends the current run
//   i_mon_ready   in   monitor ready flag
//   i_diff        in   WIDTH-bit XOR diff, nonzero = mismatch
//   o_state       out  FSM state (IDLE=0, WAIT=1, RUN=2, DONE=3)
//   o_sample_cnt  out  valid samples this run (saturating)
//   o_err_cnt     out  samples with nonzero diff (saturating)
//   o_err_flag    out  sticky, first error seen
//   o_first_diff  out  diff word of the first error
//   o_first_idx   out  sample count at the first error
//   o_bit_mask    out  sticky OR of all diff words
//   o_ready_lost  out  sticky, ready dropped while in RUN
//   o_bit_err_cnt out  (macro only) accumulated popcount of diffs
// -----------------------------------------------------------------------------
module diff_scoreboard
  import sb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = SB_CNT_W,
  parameter int STOP_AFTER = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mon_ready,
  input  logic [WIDTH-1:0] i_diff,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_sample_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_err_flag,
  output logic [WIDTH-1:0] o_first_diff,
  output logic [CNT_W-1:0] o_first_idx,
  output logic [WIDTH-1:0] o_bit_mask,
  output logic             o_ready_lost
`ifdef DIFF_SCOREBOARD_BITCNT_EN
  ,
  output logic [CNT_W-1:0] o_bit_err_cnt
`endif
);

  state_e           state_q, state_d;
  logic             valid;
  logic             diff_nz;
  logic             arm;
  logic             thr_hit;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;

  logic             err_flag_q,   err_flag_d;
  logic [WIDTH-1:0] first_diff_q, first_diff_d;
  logic [CNT_W-1:0] first_idx_q,  first_idx_d;
  logic [WIDTH-1:0] bit_mask_q,   bit_mask_d;
  logic             ready_lost_q, ready_lost_d;

  assign valid   = (state_q == RUN) && i_mon_ready;
  assign diff_nz = |i_diff;
  // Entering WAIT from IDLE/DONE is the single point where results are cleared.
  assign arm     = ((state_q == IDLE) || (state_q == DONE)) && i_start;
  // The comparison is done in 64 bits so a threshold above the counter's
  // saturation value simply never fires instead of aliasing after truncation.
  assign thr_hit = (STOP_AFTER != 0) && valid && diff_nz &&
                   ((64'(err_cnt) + 64'd1) == 64'(STOP_AFTER));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = WAIT;
      WAIT: begin
        if (i_stop) begin
          state_d = DONE;
        end else if (i_mon_ready) begin
          state_d = RUN;
        end
      end
      RUN:  if (i_stop || thr_hit) state_d = DONE;
      DONE: if (i_start) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_flag_d   = err_flag_q;
    first_diff_d = first_diff_q;
    first_idx_d  = first_idx_q;
    bit_mask_d   = bit_mask_q;
    ready_lost_d = ready_lost_q;
    if (arm) begin
      err_flag_d   = 1'b0;
      first_diff_d = '0;
      first_idx_d  = '0;
      bit_mask_d   = '0;
      ready_lost_d = 1'b0;
    end else begin
      if ((state_q == RUN) && !i_mon_ready) begin
        ready_lost_d = 1'b1;
      end
      if (valid && diff_nz) begin
        bit_mask_d = bit_mask_q | i_diff;
        if (!err_flag_q) begin
          err_flag_d   = 1'b1;
          first_diff_d = i_diff;
          // Pre-increment count; still the saturated value once saturated.
          first_idx_d  = sample_cnt;
        end
      end
    end
  end

  // Register stage: every result reflects the sample presented one cycle ago
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      err_flag_q   <= 1'b0;
      first_diff_q <= '0;
      first_idx_q  <= '0;
      bit_mask_q   <= '0;
      ready_lost_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_flag_q   <= err_flag_d;
      first_diff_q <= first_diff_d;
      first_idx_q  <= first_idx_d;
      bit_mask_q   <= bit_mask_d;
      ready_lost_q <= ready_lost_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (arm),
    .inc_en  (valid),
    .inc_val (CNT_W'(1)),
    .q       (sample_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (arm),
    .inc_en  (valid && diff_nz),
    .inc_val (CNT_W'(1)),
    .q       (err_cnt)
  );

`ifdef DIFF_SCOREBOARD_BITCNT_EN
  logic [CNT_W-1:0] diff_pop;
  assign diff_pop = CNT_W'($countones(i_diff));

  sat_counter #(.W(CNT_W)) u_bit_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (arm),
    .inc_en  (valid),
    .inc_val (diff_pop),
    .q       (o_bit_err_cnt)
  );
`endif

  assign o_state      = state_q;
  assign o_sample_cnt = sample_cnt;
  assign o_err_cnt    = err_cnt;
  assign o_err_flag   = err_flag_q;
  assign o_first_diff = first_diff_q;
  assign o_first_idx  = first_idx_q;
  assign o_bit_mask   = bit_mask_q;
  assign o_ready_lost = ready_lost_q;

endmodule

// File: tb/tb_diff_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_diff_scoreboard
// Three scoreboard instances: default parameters (inst 0), STOP_AFTER=3
// (inst 1) and CNT_W=4 (inst 2). Stimulus pushes hand-computed expectations
// tagged with the cycle at which they must hold; a monitor on the falling
// edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_diff_scoreboard;

  localparam int F_STATE = 0, F_SCNT = 1, F_ECNT = 2, F_FLAG = 3, F_FDIFF = 4,
                 F_FIDX = 5, F_MASK = 6, F_RLOST = 7, F_BCNT = 8;

  typedef struct {
    int          cyc;
    int          inst;
    int          fld;
    logic [63:0] val;
  } exp_t;

  string fname [9] = '{"state", "sample_cnt", "err_cnt", "err_flag", "first_diff",
                       "first_idx", "bit_mask", "ready_lost", "bit_err_cnt"};

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q [$];
  exp_t        mon_e;

  logic        rst_s   [3];
  logic        start_s [3];
  logic        stop_s  [3];
  logic        rdy_s   [3];
  logic [31:0] diff_s  [3];

  logic [1:0]  a_st, b_st, c_st;
  logic [31:0] a_scnt, a_ecnt, a_fidx, a_fdiff, a_mask, a_bcnt;
  logic [31:0] b_scnt, b_ecnt, b_fidx, b_fdiff, b_mask, b_bcnt;
  logic [3:0]  c_scnt, c_ecnt, c_fidx, c_bcnt;
  logic [31:0] c_fdiff, c_mask;
  logic        a_flag, a_rl, b_flag, b_rl, c_flag, c_rl;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  diff_scoreboard u_a (
    .clk(clk), .reset(rst_s[0]), .i_start(start_s[0]), .i_stop(stop_s[0]),
    .i_mon_ready(rdy_s[0]), .i_diff(diff_s[0]), .o_state(a_st),
    .o_sample_cnt(a_scnt), .o_err_cnt(a_ecnt), .o_err_flag(a_flag),
    .o_first_diff(a_fdiff), .o_first_idx(a_fidx), .o_bit_mask(a_mask),
    .o_ready_lost(a_rl)
`ifdef DIFF_SCOREBOARD_BITCNT_EN
    , .o_bit_err_cnt(a_bcnt)
`endif
  );

  diff_scoreboard #(.STOP_AFTER(3)) u_b (
    .clk(clk), .reset(rst_s[1]), .i_start(start_s[1]), .i_stop(stop_s[1]),
    .i_mon_ready(rdy_s[1]), .i_diff(diff_s[1]), .o_state(b_st),
    .o_sample_cnt(b_scnt), .o_err_cnt(b_ecnt), .o_err_flag(b_flag),
    .o_first_diff(b_fdiff), .o_first_idx(b_fidx), .o_bit_mask(b_mask),
    .o_ready_lost(b_rl)
`ifdef DIFF_SCOREBOARD_BITCNT_EN
    , .o_bit_err_cnt(b_bcnt)
`endif
  );

  diff_scoreboard #(.CNT_W(4)) u_c (
    .clk(clk), .reset(rst_s[2]), .i_start(start_s[2]), .i_stop(stop_s[2]),
    .i_mon_ready(rdy_s[2]), .i_diff(diff_s[2]), .o_state(c_st),
    .o_sample_cnt(c_scnt), .o_err_cnt(c_ecnt), .o_err_flag(c_flag),
    .o_first_diff(c_fdiff), .o_first_idx(c_fidx), .o_bit_mask(c_mask),
    .o_ready_lost(c_rl)
`ifdef DIFF_SCOREBOARD_BITCNT_EN
    , .o_bit_err_cnt(c_bcnt)
`endif
  );

`ifndef DIFF_SCOREBOARD_BITCNT_EN
  assign a_bcnt = '0;
  assign b_bcnt = '0;
  assign c_bcnt = '0;
`endif

  function automatic logic [63:0] get_field(input int k, input int f);
    logic [63:0] r [9];
    if (k == 0)
      r = '{64'(a_st), 64'(a_scnt), 64'(a_ecnt), 64'(a_flag), 64'(a_fdiff),
            64'(a_fidx), 64'(a_mask), 64'(a_rl), 64'(a_bcnt)};
    else if (k == 1)
      r = '{64'(b_st), 64'(b_scnt), 64'(b_ecnt), 64'(b_flag), 64'(b_fdiff),
            64'(b_fidx), 64'(b_mask), 64'(b_rl), 64'(b_bcnt)};
    else
      r = '{64'(c_st), 64'(c_scnt), 64'(c_ecnt), 64'(c_flag), 64'(c_fdiff),
            64'(c_fidx), 64'(c_mask), 64'(c_rl), 64'(c_bcnt)};
    return r[f];
  endfunction

  // Monitor: results are registered, so they are stable on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (get_field(mon_e.inst, mon_e.fld) !== mon_e.val) begin
        n_fail++;
        $display("FAIL inst%0d %s @cyc %0d: got %0h, expected %0h", mon_e.inst,
                 fname[mon_e.fld], cyc, get_field(mon_e.inst, mon_e.fld), mon_e.val);
      end
    end
  end

  // Expectation for the state right after the next rising edge.
  function automatic void expect_v(input int k, input int f, input logic [63:0] v);
    exp_t e;
    e.cyc  = cyc + 1;
    e.inst = k;
    e.fld  = f;
    e.val  = v;
    sb_q.push_back(e);
  endfunction

  function automatic void expect_zero(input int k);
    for (int f = 0; f < 8; f++) expect_v(k, f, 64'd0);
`ifdef DIFF_SCOREBOARD_BITCNT_EN
    expect_v(k, F_BCNT, 64'd0);
`endif
  endfunction

  task automatic drive(input int k, input logic rn, input logic st, input logic sp,
                       input logic rdy, input logic [31:0] d);
    @(negedge clk);
    rst_s[k]   = rn;
    start_s[k] = st;
    stop_s[k]  = sp;
    rdy_s[k]   = rdy;
    diff_s[k]  = d;
  endtask

  initial begin
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b0; start_s[k] = 1'b0; stop_s[k] = 1'b0;
      rdy_s[k] = 1'b0; diff_s[k] = '0;
    end

    // ---- inst 0: reset, arm, ready path ----
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
    expect_zero(0);
    drive(0, 1, 1, 0, 0, 0);  expect_v(0, F_STATE, 1); expect_v(0, F_SCNT, 0);
    drive(0, 1, 0, 0, 0, 0);  expect_v(0, F_STATE, 1);
    drive(0, 1, 0, 0, 1, 0);  expect_v(0, F_STATE, 2); expect_v(0, F_SCNT, 0);

    // ---- counting and first-error capture; stop rides on the 10th sample ----
    for (int k = 0; k < 10; k++) begin
      d = (k == 4) ? 32'h0000_0100 : (k == 7) ? 32'h8000_0001 : 32'h0;
      drive(0, 1, 0, (k == 9), 1, d);
      expect_v(0, F_SCNT, k + 1);
      if (k == 4) begin
        expect_v(0, F_FLAG, 1); expect_v(0, F_FIDX, 4);
        expect_v(0, F_FDIFF, 32'h100); expect_v(0, F_ECNT, 1);
      end
    end
    expect_v(0, F_STATE, 3); expect_v(0, F_ECNT, 2); expect_v(0, F_FIDX, 4);
    expect_v(0, F_FDIFF, 32'h100); expect_v(0, F_MASK, 32'h8000_0101);
    expect_v(0, F_RLOST, 0); expect_v(0, F_FLAG, 1);

    // ---- DONE holds results ----
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 1, 32'hFFFF);
      expect_v(0, F_SCNT, 10); expect_v(0, F_MASK, 32'h8000_0101); expect_v(0, F_STATE, 3);
    end

    // ---- re-arm from DONE (start beats stop) clears everything ----
    drive(0, 1, 1, 1, 1, 0);
    expect_v(0, F_STATE, 1); expect_v(0, F_SCNT, 0); expect_v(0, F_ECNT, 0);
    expect_v(0, F_FLAG, 0); expect_v(0, F_FDIFF, 0); expect_v(0, F_FIDX, 0);
    expect_v(0, F_MASK, 0); expect_v(0, F_RLOST, 0);
    drive(0, 1, 0, 0, 1, 0);  expect_v(0, F_STATE, 2);

    // ---- ready drop mid-run ----
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1, 0);
    expect_v(0, F_SCNT, 3);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0, 32'hFF);
      expect_v(0, F_RLOST, 1); expect_v(0, F_STATE, 2); expect_v(0, F_SCNT, 3);
    end
    drive(0, 1, 0, 0, 1, 32'h3);
    expect_v(0, F_SCNT, 4); expect_v(0, F_ECNT, 1); expect_v(0, F_FIDX, 3);
    expect_v(0, F_FDIFF, 32'h3);
    drive(0, 1, 0, 0, 1, 32'hF);
    expect_v(0, F_SCNT, 5); expect_v(0, F_ECNT, 2); expect_v(0, F_MASK, 32'hF);
    expect_v(0, F_FIDX, 3); expect_v(0, F_FDIFF, 32'h3); expect_v(0, F_STATE, 2);
    expect_v(0, F_RLOST, 1);
`ifdef DIFF_SCOREBOARD_BITCNT_EN
    expect_v(0, F_BCNT, 6);
`endif

    // ---- start ignored in RUN; then mid-run reset wipes all ----
    drive(0, 1, 1, 0, 0, 0);  expect_v(0, F_STATE, 2); expect_v(0, F_SCNT, 5);
    drive(0, 0, 0, 0, 1, 32'h1);
    expect_zero(0);
    drive(0, 1, 1, 1, 0, 0);  expect_v(0, F_STATE, 1);
    // WAIT with start+stop+ready: stop wins
    drive(0, 1, 1, 1, 1, 0);  expect_v(0, F_STATE, 3); expect_v(0, F_SCNT, 0);
    drive(0, 1, 0, 0, 0, 0);

    // ---- inst 1: threshold halt at 3 errors ----
    for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 0, 0);
    expect_zero(1);
    drive(1, 1, 1, 0, 0, 0);  expect_v(1, F_STATE, 1);
    drive(1, 1, 0, 0, 1, 0);  expect_v(1, F_STATE, 2);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0, 0, 1, 32'h1);
      if (k == 1) begin expect_v(1, F_STATE, 2); expect_v(1, F_ECNT, 2); end
      if (k == 2) begin
        expect_v(1, F_STATE, 3); expect_v(1, F_SCNT, 3); expect_v(1, F_ECNT, 3);
      end
    end
    expect_v(1, F_SCNT, 3); expect_v(1, F_ECNT, 3); expect_v(1, F_STATE, 3);
    expect_v(1, F_FLAG, 1); expect_v(1, F_FIDX, 0);

    // ---- inst 2: 4-bit counters saturate ----
    for (int i = 0; i < 2; i++) drive(2, 0, 0, 0, 0, 0);
    expect_zero(2);
    drive(2, 1, 1, 0, 0, 0);  expect_v(2, F_STATE, 1);
    drive(2, 1, 0, 0, 1, 0);  expect_v(2, F_STATE, 2);
    for (int k = 0; k < 20; k++) begin
      drive(2, 1, 0, 0, 1, 32'h1);
      if (k == 13) begin expect_v(2, F_SCNT, 14); expect_v(2, F_ECNT, 14); end
      if (k == 14) begin expect_v(2, F_SCNT, 15); expect_v(2, F_ECNT, 15); end
    end
    expect_v(2, F_SCNT, 15); expect_v(2, F_ECNT, 15); expect_v(2, F_FIDX, 0);
    expect_v(2, F_MASK, 1); expect_v(2, F_STATE, 2);
`ifdef DIFF_SCOREBOARD_BITCNT_EN
    expect_v(2, F_BCNT, 15);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/diff_scoreboard.md
Name: diff_scoreboard

Overview:
- Sits directly downstream of the arithmetic monitor and consumes its ready flag and per-cycle XOR diff word.
- Provides run control, sample and error counts, and first-failure capture.
- Provides a sticky OR mask of failing bits and an optional stop-on-error-threshold.
- Results are register outputs read by the testbench top and host logic.

Parameters:
- WIDTH, 32, width of the monitor diff word.
- CNT_W, 32, width of the sample and error counters.
- STOP_AFTER, 0, error count at which the run halts automatically; 0 = never halt.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low; asserted when 0, sampled on posedge clk.
- i_start  in  1  one-cycle pulse; arms a new run.
- i_stop  in  1  one-cycle pulse; ends the current run.
- i_mon_ready  in  1  monitor-ready flag from the upstream monitor.
- i_diff  in  WIDTH  registered XOR diff from the monitor; nonzero = mismatch.
- o_state  out  2  current FSM state.
- o_sample_cnt  out  CNT_W  valid samples checked this run.
- o_err_cnt  out  CNT_W  samples with nonzero diff.
- o_err_flag  out  1  sticky; set on the first error of a run.
- o_first_diff  out  WIDTH  diff word of the first error.
- o_first_idx  out  CNT_W  value of o_sample_cnt at the first error.
- o_bit_mask  out  WIDTH  sticky OR of all diff words this run.
- o_ready_lost  out  1  sticky; i_mon_ready fell while in RUN.

Behaviour:
- Reset (reset==0 on a posedge): state=IDLE; all outputs 0. Reset mid-run discards all results with no partial update.
- FSM encoding: IDLE=0, WAIT=1, RUN=2, DONE=3.
  - IDLE: i_start -> WAIT.
  - WAIT: i_mon_ready==1 -> RUN; i_stop -> DONE.
  - RUN: i_stop -> DONE; stop-threshold hit -> DONE.
  - DONE: i_start -> WAIT.
- Clearing: entry into WAIT from IDLE or DONE clears every counter, flag, capture register and mask in that same cycle.
- Valid sample: state==RUN AND i_mon_ready==1. Only valid samples update anything.
- On each valid sample:
  - o_sample_cnt increments, saturating at all-ones.
  - If i_diff!=0: o_err_cnt increments (saturating) and o_bit_mask |= i_diff.
  - If i_diff!=0 and o_err_flag==0: o_first_diff <= i_diff; o_first_idx <= the pre-increment o_sample_cnt; o_err_flag <= 1.
- Latency: every output reflects a sample one cycle after that sample is presented.
- i_stop on the same cycle as a valid sample: the sample is counted, then the FSM goes to DONE.
- i_start and i_stop together:
  - In IDLE or DONE, i_start wins.
  - In WAIT or RUN, i_stop wins.
- Threshold halt: if STOP_AFTER!=0 and a valid error sample makes o_err_cnt equal to STOP_AFTER, the next state is DONE. That sample is counted; nothing after it is.
- Ready loss: i_mon_ready==0 while in RUN sets o_ready_lost. The state stays RUN, and samples resume when ready returns.
- DONE holds all results until the next i_start or reset.
- Saturation: counters never wrap. In the saturated state o_first_idx keeps capturing the saturated count.

Optional Feature:
- Macro: DIFF_SCOREBOARD_BITCNT_EN.
- Defined: adds output o_bit_err_cnt (CNT_W). It accumulates the popcount of i_diff on every valid sample, saturating, with the same clear and reset rules as the other counters. The popcount is combinational; the accumulator is registered with the same one-cycle latency.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sb_pkg holds:
  - the state encoding constants IDLE/WAIT/RUN/DONE;
  - default CNT_W;
  - a saturating-add helper function.
- One sub-module, sat_counter (params W; ports clk, reset, clr, inc_en, inc_val, q), saturating at all-ones. It is instantiated for sample count, error count and, under DIFF_SCOREBOARD_BITCNT_EN, the bit-error count.

Test Plan:
- Reset and ready path: reset=0 for 3 cycles, then 1; pulse i_start; i_mon_ready=1 from cycle 5 -> o_state goes 0 -> 1 -> 2; all counts 0 before RUN.
- Counting and capture: 10 valid samples with i_diff=0, except sample index 4 (diff=32'h0000_0100) and index 7 (diff=32'h8000_0001), then i_stop -> o_sample_cnt=10, o_err_cnt=2, o_first_idx=4, o_first_diff=32'h0000_0100, o_bit_mask=32'h8000_0101, o_state=3.
- Threshold halt: STOP_AFTER=3, all diffs 32'h1 -> DONE after the 3rd sample; o_sample_cnt=3, o_err_cnt=3; later samples ignored.
- Ready drop: drop i_mon_ready for 2 cycles mid-RUN with 5 valid samples total -> o_ready_lost=1, o_sample_cnt=5, state stays RUN.
- Saturation: CNT_W=4, 20 error samples -> o_sample_cnt=15, o_err_cnt=15, no wrap.
- Re-arm and mid-run reset: i_start from DONE clears all results; reset=0 mid-RUN -> all outputs 0, state IDLE. Under DIFF_SCOREBOARD_BITCNT_EN, diffs 32'h3 and 32'hF -> o_bit_err_cnt=6.
